mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one synchronous single-port Memory32 between two requesters: port 0 (pipeline, mem_* bus) and port 1 (DMA/debug loader).
- Grant is decided in the same cycle as the request. Read data returns one cycle after grant, the same timing as Memory32.
- Port 0 has fixed priority. An anti-starvation counter forces port 1 through after a bounded wait.
- Sits between Pipeline/loader and Memory32 in the SoC top and benches.

Parameters:
STARVE_LIMIT, 4, cycles port 1 may wait while requesting before it is forced; legal range 1..15; 1 gives strict alternation under continuous contention
CNT_WIDTH, 32, width of the contention statistics counter

Ports:
clk  in  1  clock, all state updates on rising edge
rstn  in  1  reset, asynchronous, active-low
m0_valid  in  1  port 0 request
m0_write  in  1  port 0 write (1) / read (0)
m0_wmask  in  4  port 0 byte write mask
m0_wdata  in  32  port 0 write data
m0_addr  in  32  port 0 byte address
m0_ready  out  1  port 0 granted this cycle (combinational)
m0_rvalid  out  1  port 0 read data valid (cycle after read grant)
m0_rdata  out  32  port 0 read data
m1_valid, m1_write, m1_wmask, m1_wdata, m1_addr, m1_ready, m1_rvalid, m1_rdata: same as port 0, for port 1
mem_valid  out  1  to Memory32
mem_write  out  1  to Memory32
mem_wmask  out  4  to Memory32
mem_wdata  out  32  to Memory32
mem_addr  out  32  to Memory32, byte address (top slices [14:2])
mem_rdata  in  32  from Memory32, valid one cycle after a read access
conflict_cnt  out  CNT_WIDTH  cycles with both ports requesting

Behaviour:
- Reset (rstn low, asynchronous): wait_cnt=0, r_pending=0, r_owner=0, conflict_cnt=0. Therefore m0_rvalid=m1_rvalid=0.
- While in reset, ready/mem_valid remain a combinational function of the inputs. The bench holds valid low during reset.
- force1 = (wait_cnt >= STARVE_LIMIT).
- grant0 = m0_valid & ~(force1 & m1_valid).
- grant1 = m1_valid & ~grant0.
- At most one grant per cycle. mX_ready = grantX.
- mem_valid = grant0 | grant1. mem_write/wmask/wdata/addr are muxed from the granted port.
- When no grant: mem_valid=0, mem_write=0, mem_wmask=0, and address/data come from port 0.
- An ungranted requester must hold valid and all request fields stable until ready. The arbiter latches nothing from it.
- wait_cnt (4-bit):
  - m1_valid & ~grant1 → increment, saturating at STARVE_LIMIT.
  - Otherwise → 0.
- Read tracking:
  - On a read grant (mem_valid & ~mem_write): r_pending<=1 and r_owner<=granted index.
  - On any other cycle: r_pending<=0.
- Read response, in the cycle after the grant:
  - mX_rvalid = r_pending & (r_owner==X).
  - m0_rdata = m1_rdata = mem_rdata, unconditionally routed; rvalid identifies the owner.
- Back-to-back reads are supported: a new grant in the response cycle overwrites r_owner for the following cycle. Throughput is 1 access/cycle.
- Writes produce no response. Write data and mask are presented in the grant cycle.
- conflict_cnt increments when m0_valid & m1_valid, and wraps at 2^CNT_WIDTH.
- Simultaneous events:
  - Forced grant to port 1 while port 0 requests: port 0 sees ready=0 and must hold.
  - Forced grant resets wait_cnt to 0 on the next edge.
  - A port 1 request alone is granted immediately regardless of wait_cnt.
- Reset asserted mid-read: the pending response is dropped (rvalid=0 from reset onward). Requesters must reissue.

Test Plan:
- Port 0 only, read 0x00000100 (mem word 0x40 = 0xDEADBEEF) → m0_ready=1 same cycle, next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- Port 1 only, write 0x00000200 data 0x12345678 mask 4'b0011 → m1_ready=1, mem_wmask=0011, mem_addr=0x200. A later port 0 read of the same address returns 0xXXXX5678 (upper bytes unchanged).
- Both requesting continuously, STARVE_LIMIT=4 → grant sequence 0,0,0,0,1,0,0,0,0,1…; conflict_cnt increments every cycle.
- STARVE_LIMIT=1, both reading continuously → alternation 0,1,0,1; each rvalid appears exactly one cycle after its own grant, never on the other port.
- Port 1 waiting with wait_cnt=3, port 0 drops valid → port 1 granted immediately, wait_cnt returns to 0.
- Port 0 read granted, rstn pulled low before the next edge → m0_rvalid stays 0. After release, conflict_cnt=0 and wait_cnt=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port Memory32 between a fixed-priority port 0
// and a port 1 that is forced through after STARVE_LIMIT cycles of waiting.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 m0_valid,
    input  logic                 m0_write,
    input  logic [3:0]           m0_wmask,
    input  logic [31:0]          m0_wdata,
    input  logic [31:0]          m0_addr,
    output logic                 m0_ready,
    output logic                 m0_rvalid,
    output logic [31:0]          m0_rdata,
    input  logic                 m1_valid,
    input  logic                 m1_write,
    input  logic [3:0]           m1_wmask,
    input  logic [31:0]          m1_wdata,
    input  logic [31:0]          m1_addr,
    output logic                 m1_ready,
    output logic                 m1_rvalid,
    output logic [31:0]          m1_rdata,
    output logic                 mem_valid,
    output logic                 mem_write,
    output logic [3:0]           mem_wmask,
    output logic [31:0]          mem_wdata,
    output logic [31:0]          mem_addr,
    input  logic [31:0]          mem_rdata,
    output logic [CNT_WIDTH-1:0] conflict_cnt
);
    logic [3:0] wait_cnt;
    logic       r_pending;
    logic       r_owner;
    logic       force1;
    logic       grant0;
    logic       grant1;

    always_comb begin
        force1    = wait_cnt >= 4'(STARVE_LIMIT);
        grant0    = m0_valid & ~(force1 & m1_valid);
        grant1    = m1_valid & ~grant0;
        m0_ready  = grant0;
        m1_ready  = grant1;
        mem_valid = grant0 | grant1;
        mem_write = grant0 ? m0_write : grant1 ? m1_write : 1'b0;
        mem_wmask = grant0 ? m0_wmask : grant1 ? m1_wmask : 4'd0;
        mem_wdata = grant1 ? m1_wdata : m0_wdata;
        mem_addr  = grant1 ? m1_addr : m0_addr;
        m0_rvalid = r_pending & ~r_owner;
        m1_rvalid = r_pending & r_owner;
        m0_rdata  = mem_rdata;
        m1_rdata  = mem_rdata;
    end

    // wait_cnt only counts while port 1 is actually being held off
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt     <= 4'd0;
            r_pending    <= 1'b0;
            r_owner      <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            wait_cnt     <= (m1_valid & ~grant1) ? (force1 ? wait_cnt : wait_cnt + 4'd1) : 4'd0;
            r_pending    <= mem_valid & ~mem_write;
            r_owner      <= (mem_valid & ~mem_write) ? grant1 : r_owner;
            conflict_cnt <= conflict_cnt + CNT_WIDTH'(m0_valid & m1_valid);
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for starvation,
// strict alternation and reset-during-read.
module tb_mem_arbiter;
    typedef struct {
        logic        v0, w0;
        logic [3:0]  k0;
        logic [31:0] a0, d0;
        logic        v1, w1;
        logic [3:0]  k1;
        logic [31:0] a1, d1;
        logic [1:0]  g;
        logic [1:0]  rv;
        logic [31:0] rd;
    } vec_t;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        m0_valid = 0, m0_write = 0, m1_valid = 0, m1_write = 0;
    logic [3:0]  m0_wmask = 0, m1_wmask = 0;
    logic [31:0] m0_wdata = 0, m0_addr = 0, m1_wdata = 0, m1_addr = 0;
    logic        m0_ready, m0_rvalid, m1_ready, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_valid, mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata, mem_addr, mem_rdata;
    logic [31:0] conflict_cnt;

    logic        n0_valid = 0, n1_valid = 0;
    logic        n0_ready, n0_rvalid, n1_ready, n1_rvalid;
    logic [31:0] n0_rdata, n1_rdata;
    logic        n_mem_valid, n_mem_write;
    logic [3:0]  n_mem_wmask;
    logic [31:0] n_mem_wdata, n_mem_addr, n_mem_rdata;
    logic [31:0] n_conflict_cnt;

    logic [31:0] mem [0:8191];
    int          n_chk = 0;
    int          n_fail = 0;
    vec_t        tbl [24];

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .m0_valid(m0_valid), .m0_write(m0_write), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
        .m0_addr(m0_addr), .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_write(m1_write), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
        .m1_addr(m1_addr), .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    mem_arbiter #(.STARVE_LIMIT(1), .CNT_WIDTH(32)) dut1 (
        .clk(clk), .rstn(rstn),
        .m0_valid(n0_valid), .m0_write(1'b0), .m0_wmask(4'd0), .m0_wdata(32'd0),
        .m0_addr(32'h10), .m0_ready(n0_ready), .m0_rvalid(n0_rvalid), .m0_rdata(n0_rdata),
        .m1_valid(n1_valid), .m1_write(1'b0), .m1_wmask(4'd0), .m1_wdata(32'd0),
        .m1_addr(32'h20), .m1_ready(n1_ready), .m1_rvalid(n1_rvalid), .m1_rdata(n1_rdata),
        .mem_valid(n_mem_valid), .mem_write(n_mem_write), .mem_wmask(n_mem_wmask),
        .mem_wdata(n_mem_wdata), .mem_addr(n_mem_addr), .mem_rdata(n_mem_rdata),
        .conflict_cnt(n_conflict_cnt)
    );

    // Memory32 model: byte-masked write, read data one cycle after access
    always @(posedge clk) begin
        if (mem_valid && mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_addr[14:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else if (mem_valid) begin
            mem_rdata <= mem[mem_addr[14:2]];
        end
        if (n_mem_valid && !n_mem_write) n_mem_rdata <= n_mem_addr + 32'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t vec(input logic v0, w0, input logic [3:0] k0, input logic [31:0] a0, d0,
                                 input logic v1, w1, input logic [3:0] k1, input logic [31:0] a1, d1,
                                 input logic [1:0] g, rv, input logic [31:0] rd);
        vec_t r;
        r.v0 = v0; r.w0 = w0; r.k0 = k0; r.a0 = a0; r.d0 = d0;
        r.v1 = v1; r.w1 = w1; r.k1 = k1; r.a1 = a1; r.d1 = d1;
        r.g = g; r.rv = rv; r.rd = rd;
        return r;
    endfunction

    function automatic vec_t idle(input logic [1:0] rv, input logic [31:0] rd);
        return vec(0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0, 2'd0, rv, rd);
    endfunction

    function automatic vec_t both(input logic [1:0] g, rv, input logic [31:0] rd);
        return vec(1, 0, 4'd0, A0, 32'd0, 1, 0, 4'd0, A1, 32'd0, g, rv, rd);
    endfunction

    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        m0_valid = t.v0; m0_write = t.w0; m0_wmask = t.k0; m0_addr = t.a0; m0_wdata = t.d0;
        m1_valid = t.v1; m1_write = t.w1; m1_wmask = t.k1; m1_addr = t.a1; m1_wdata = t.d1;
        #1;
        chk({tag, " m0_ready"}, 32'(m0_ready), 32'(t.g == 2'd1));
        chk({tag, " m1_ready"}, 32'(m1_ready), 32'(t.g == 2'd2));
        chk({tag, " mem_valid"}, 32'(mem_valid), 32'(t.g != 2'd0));
        chk({tag, " mem_write"}, 32'(mem_write), 32'(t.g == 2'd1 ? t.w0 : t.g == 2'd2 ? t.w1 : 1'b0));
        chk({tag, " mem_wmask"}, 32'(mem_wmask), 32'(t.g == 2'd1 ? t.k0 : t.g == 2'd2 ? t.k1 : 4'd0));
        chk({tag, " mem_addr"}, mem_addr, t.g == 2'd2 ? t.a1 : t.a0);
        chk({tag, " mem_wdata"}, mem_wdata, t.g == 2'd2 ? t.d1 : t.d0);
        chk({tag, " rvalid"}, 32'({m1_rvalid, m0_rvalid}), 32'(t.rv));
        if (t.rv != 2'd0) begin
            chk({tag, " m0_rdata"}, m0_rdata, t.rd);
            chk({tag, " m1_rdata"}, m1_rdata, t.rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        mem[32'h40] = 32'hDEAD_BEEF;
        mem[32'h80] = 32'hAABB_CCDD;
        tbl[0]  = idle(2'b00, 0);
        tbl[1]  = vec(1, 0, 4'd0, A0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0, 2'd1, 2'b00, 0);
        tbl[2]  = idle(2'b01, 32'hDEAD_BEEF);
        tbl[3]  = vec(0, 0, 4'd0, 32'd0, 32'd0, 1, 1, 4'b0011, A1, 32'h1234_5678, 2'd2, 2'b00, 0);
        tbl[4]  = vec(1, 0, 4'd0, A1, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0, 2'd1, 2'b00, 0);
        tbl[5]  = idle(2'b01, 32'hAABB_5678);
        tbl[6]  = both(2'd1, 2'b00, 0);
        tbl[7]  = both(2'd1, 2'b01, 32'hDEAD_BEEF);
        tbl[8]  = both(2'd1, 2'b01, 32'hDEAD_BEEF);
        tbl[9]  = both(2'd1, 2'b01, 32'hDEAD_BEEF);
        tbl[10] = both(2'd2, 2'b01, 32'hDEAD_BEEF);
        tbl[11] = both(2'd1, 2'b10, 32'hAABB_5678);
        tbl[12] = both(2'd1, 2'b01, 32'hDEAD_BEEF);
        tbl[13] = both(2'd1, 2'b01, 32'hDEAD_BEEF);
        tbl[14] = vec(0, 0, 4'd0, 32'd0, 32'd0, 1, 0, 4'd0, A1, 32'd0, 2'd2, 2'b01, 32'hDEAD_BEEF);
        tbl[15] = both(2'd1, 2'b10, 32'hAABB_5678);
        tbl[16] = both(2'd1, 2'b01, 32'hDEAD_BEEF);
        tbl[17] = both(2'd1, 2'b01, 32'hDEAD_BEEF);
        tbl[18] = both(2'd1, 2'b01, 32'hDEAD_BEEF);
        tbl[19] = both(2'd2, 2'b01, 32'hDEAD_BEEF);
        tbl[20] = idle(2'b10, 32'hAABB_5678);
        tbl[21] = vec(1, 1, 4'b1111, A0, 32'hCAFE_F00D, 0, 0, 4'd0, 32'd0, 32'd0, 2'd1, 2'b00, 0);
        tbl[22] = vec(1, 0, 4'd0, A0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0, 2'd1, 2'b00, 0);
        tbl[23] = idle(2'b01, 32'hCAFE_F00D);

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("reset rvalid", 32'({m1_rvalid, m0_rvalid, n1_rvalid, n0_rvalid}), 32'd0);
        chk("reset conflict_cnt", conflict_cnt, 32'd0);
        chk("reset n_conflict_cnt", n_conflict_cnt, 32'd0);

        for (int i = 0; i < 24; i++) apply(tbl[i], $sformatf("row%0d", i));
        chk("conflict_cnt after table", conflict_cnt, 32'd13);

        // strict alternation with STARVE_LIMIT=1
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n0_valid = 1'b1; n1_valid = 1'b1;
            #1;
            chk($sformatf("alt%0d n0_ready", i), 32'(n0_ready), 32'(i % 2 == 0));
            chk($sformatf("alt%0d n1_ready", i), 32'(n1_ready), 32'(i % 2 == 1));
            chk($sformatf("alt%0d rvalid", i), 32'({n1_rvalid, n0_rvalid}),
                i == 0 ? 32'd0 : (i % 2 == 1 ? 32'd1 : 32'd2));
            if (i > 0) chk($sformatf("alt%0d rdata", i), i % 2 == 1 ? n0_rdata : n1_rdata,
                           i % 2 == 1 ? 32'h11 : 32'h21);
        end
        @(negedge clk);
        n0_valid = 1'b0; n1_valid = 1'b0;
        #1;
        chk("alt n_conflict_cnt", n_conflict_cnt, 32'd8);

        // reset lands between a port 0 read grant and its response
        apply(both(2'd1, 2'b00, 0), "pre0");
        apply(both(2'd1, 2'b01, 32'hCAFE_F00D), "pre1");
        apply(both(2'd1, 2'b01, 32'hCAFE_F00D), "pre2");
        apply(both(2'd1, 2'b01, 32'hCAFE_F00D), "pre3");
        #2;
        rstn = 1'b0;
        m0_valid = 1'b0; m1_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid-reset m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("mid-reset conflict_cnt", conflict_cnt, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post-reset rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        apply(both(2'd1, 2'b00, 0), "post0");
        apply(both(2'd1, 2'b01, 32'hCAFE_F00D), "post1");
        apply(both(2'd1, 2'b01, 32'hCAFE_F00D), "post2");
        apply(both(2'd1, 2'b01, 32'hCAFE_F00D), "post3");
        apply(both(2'd2, 2'b01, 32'hCAFE_F00D), "post4");
        apply(idle(2'b10, 32'hAABB_5678), "post5");
        chk("post-reset conflict_cnt", conflict_cnt, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
